// File: rtl/cacheline_burst_writer.sv
// Write-back adapter: captures one dirty cache line and emits it to burst memory
// as BEATS consecutive beats, then pulses dfp_resp once.
module cacheline_burst_writer #(
    parameter int unsigned LINE_WIDTH = 256,
    parameter int unsigned BEAT_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [31:0]           dfp_addr,
    input  logic                  dfp_write,
    input  logic [LINE_WIDTH-1:0] dfp_wdata,
    output logic                  dfp_resp,
    output logic                  busy,
    output logic [31:0]           bmem_addr,
    output logic                  bmem_write,
    output logic [BEAT_WIDTH-1:0] bmem_wdata,
    input  logic                  bmem_ready
);

    localparam int unsigned BEATS      = LINE_WIDTH / BEAT_WIDTH;
    localparam int unsigned BEAT_IDX_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int unsigned ADDR_W     = 32;
    localparam int unsigned OFFSET_W   = $clog2(LINE_WIDTH / 8);
    localparam logic [BEAT_IDX_W-1:0] LAST_BEAT = BEAT_IDX_W'(BEATS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t                         state, state_n;
    logic [BEAT_IDX_W-1:0]          beat, beat_n;
    logic [ADDR_W-1:0]              addr_q, addr_n;
    logic [BEATS-1:0][BEAT_WIDTH-1:0] line_q, line_n;

    logic                  resp_n;
    logic                  busy_n;
    logic                  write_n;
    logic [ADDR_W-1:0]     baddr_n;
    logic [BEAT_WIDTH-1:0] bdata_n;

    // Line offset bits are dropped when the address is aligned.
    logic unused_offset;
    assign unused_offset = ^dfp_addr[OFFSET_W-1:0];

    // Next-state, capture and next-output decode.
    always_comb begin
        state_n = state;
        beat_n  = beat;
        addr_n  = addr_q;
        line_n  = line_q;

        case (state)
            IDLE: begin
                if (dfp_write) begin
                    state_n = BURST;
                    beat_n  = '0;
                    addr_n  = {dfp_addr[ADDR_W-1:OFFSET_W], OFFSET_W'(0)};
                    line_n  = dfp_wdata;
                end
            end
            BURST: begin
                // Only the first beat waits for ready; the rest stream back-to-back.
                if ((beat != '0) || bmem_ready) begin
                    beat_n = beat + BEAT_IDX_W'(1);
                    if (beat == LAST_BEAT) begin
                        state_n = RESP;
                    end
                end
            end
            RESP: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        write_n = (state_n == BURST);
        resp_n  = (state_n == RESP);
        busy_n  = (state_n != IDLE);
        baddr_n = write_n ? addr_n : '0;
        bdata_n = write_n ? line_n[beat_n] : '0;
    end

    // State, capture registers and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            beat       <= '0;
            addr_q     <= '0;
            line_q     <= '0;
            dfp_resp   <= 1'b0;
            busy       <= 1'b0;
            bmem_write <= 1'b0;
            bmem_addr  <= '0;
            bmem_wdata <= '0;
        end else begin
            state      <= state_n;
            beat       <= beat_n;
            addr_q     <= addr_n;
            line_q     <= line_n;
            dfp_resp   <= resp_n;
            busy       <= busy_n;
            bmem_write <= write_n;
            bmem_addr  <= baddr_n;
            bmem_wdata <= bdata_n;
        end
    end

endmodule

// File: tb/tb_cacheline_burst_writer.sv
// Scoreboard bench for cacheline_burst_writer: stimulus queues expected beats and
// responses with their cycle numbers; a negedge monitor pops and compares them.
module tb_cacheline_burst_writer;

    logic         clk;
    logic         rst;
    logic [31:0]  dfp_addr;
    logic         dfp_write;
    logic [255:0] dfp_wdata;
    logic         dfp_resp;
    logic         busy;
    logic [31:0]  bmem_addr;
    logic         bmem_write;
    logic [63:0]  bmem_wdata;
    logic         bmem_ready;

    cacheline_burst_writer #(
        .LINE_WIDTH(256),
        .BEAT_WIDTH(64)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .dfp_addr  (dfp_addr),
        .dfp_write (dfp_write),
        .dfp_wdata (dfp_wdata),
        .dfp_resp  (dfp_resp),
        .busy      (busy),
        .bmem_addr (bmem_addr),
        .bmem_write(bmem_write),
        .bmem_wdata(bmem_wdata),
        .bmem_ready(bmem_ready)
    );

    typedef struct {
        bit          is_resp;
        int          cyc;
        logic [31:0] addr;
        logic [63:0] data;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   n_total = 0;
    int   n_pass = 0;
    bit   mon_en = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every bus beat and response must match the head of the queue.
    always @(negedge clk) begin
        if (mon_en) begin
            if (bmem_write) begin
                chk("beat_expected", 64'(q.size() > 0 && !q[0].is_resp), 64'd1);
                if (q.size() > 0 && !q[0].is_resp) begin
                    chk("beat_cycle", 64'(q[0].cyc), 64'(cyc));
                    chk("beat_addr", 64'(bmem_addr), 64'(q[0].addr));
                    chk("beat_data", bmem_wdata, q[0].data);
                    void'(q.pop_front());
                end
            end else begin
                chk("idle_addr_zero", 64'(bmem_addr), 64'd0);
                chk("idle_data_zero", bmem_wdata, 64'd0);
            end
            if (dfp_resp) begin
                chk("resp_expected", 64'(q.size() > 0 && q[0].is_resp), 64'd1);
                if (q.size() > 0 && q[0].is_resp) begin
                    chk("resp_cycle", 64'(q[0].cyc), 64'(cyc));
                    void'(q.pop_front());
                end
            end
        end
    end

    // Issue one line; stall = ready-low cycles at beat 0, drop = ready low for beats 1-3,
    // corrupt = change the request inputs mid-burst. Returns in the IDLE cycle after resp.
    task automatic issue(input logic [31:0] a, input logic [255:0] l, input int stall,
                         input bit drop, input bit corrupt);
        int          n;
        logic [31:0] al;
        exp_t        e;
        n  = cyc;
        al = {a[31:5], 5'b0};
        dfp_write  = 1'b1;
        dfp_addr   = a;
        dfp_wdata  = l;
        bmem_ready = (stall == 0);
        for (int i = 0; i <= stall; i++) begin
            e = '{is_resp: 1'b0, cyc: n + 1 + i, addr: al, data: l[63:0]};
            q.push_back(e);
        end
        for (int b = 1; b < 4; b++) begin
            e = '{is_resp: 1'b0, cyc: n + 1 + stall + b, addr: al, data: l[b*64 +: 64]};
            q.push_back(e);
        end
        e = '{is_resp: 1'b1, cyc: n + 5 + stall, addr: 32'd0, data: 64'd0};
        q.push_back(e);
        for (int k = 1; k <= 5 + stall; k++) begin
            step();
            chk("busy_high", 64'(busy), 64'd1);
            bmem_ready = drop ? (k == stall + 1) : (k > stall);
            if (corrupt && k == 2) begin
                dfp_wdata = '1;
                dfp_addr  = 32'hFFFF_FFE0;
            end
        end
        step();
        chk("busy_low_after_resp", 64'(busy), 64'd0);
        bmem_ready = 1'b1;
    endtask

    task automatic quiet(input int cycles);
        dfp_write = 1'b0;
        repeat (cycles) step();
    endtask

    logic [255:0] line_a, line_b, line_c, line_d;

    initial begin
        int n;
        exp_t e;
        rst        = 1'b1;
        dfp_write  = 1'b1;
        dfp_addr   = 32'hDEAD_BEEF;
        dfp_wdata  = {4{64'h0123_4567_89AB_CDEF}};
        bmem_ready = 1'b1;
        line_a = {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
                  64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA};
        line_b = {64'h4444_0000_0000_0004, 64'h3333_0000_0000_0003,
                  64'h2222_0000_0000_0002, 64'h1111_0000_0000_0001};
        line_c = {64'hF0F0_F0F0_0F0F_0F0F, 64'h1234_5678_9ABC_DEF0,
                  64'h0000_0000_FFFF_FFFF, 64'h5A5A_A5A5_5A5A_A5A5};
        line_d = {64'h8000_0000_0000_0008, 64'h0700_0000_0000_0070,
                  64'h0060_0000_0000_0600, 64'h0005_0000_0000_5000};

        // Reset with a pending request: reset must win.
        step();
        step();
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_write", 64'(bmem_write), 64'd0);
        chk("rst_resp", 64'(dfp_resp), 64'd0);
        chk("rst_addr", 64'(bmem_addr), 64'd0);
        chk("rst_data", bmem_wdata, 64'd0);
        rst       = 1'b0;
        dfp_write = 1'b0;
        mon_en    = 1'b1;
        step();
        chk("no_capture_in_reset", 64'(busy), 64'd0);

        issue(32'h1234_567F, line_a, 0, 1'b0, 1'b0);   // basic
        quiet(2);
        issue(32'h0000_1000, line_b, 3, 1'b0, 1'b0);   // backpressure at beat 0
        quiet(2);
        issue(32'h8000_0047, line_c, 0, 1'b1, 1'b0);   // ready drop during beats 1-3
        quiet(2);
        issue(32'h0BAD_F00D, line_d, 1, 1'b0, 1'b1);   // inputs change mid-burst
        quiet(2);
        issue(32'h0000_0020, line_a, 0, 1'b0, 1'b0);   // back-to-back pair
        issue(32'h0000_0040, line_b, 0, 1'b0, 1'b0);
        quiet(2);

        // Reset while beat 2 is on the bus.
        n = cyc;
        dfp_write  = 1'b1;
        dfp_addr   = 32'h0000_ABCD;
        dfp_wdata  = line_c;
        bmem_ready = 1'b1;
        for (int b = 0; b < 3; b++) begin
            e = '{is_resp: 1'b0, cyc: n + 1 + b, addr: 32'h0000_ABC0, data: line_c[b*64 +: 64]};
            q.push_back(e);
        end
        step();
        step();
        step();
        rst       = 1'b1;
        dfp_write = 1'b0;
        step();
        chk("midrst_write", 64'(bmem_write), 64'd0);
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_resp", 64'(dfp_resp), 64'd0);
        chk("midrst_addr", 64'(bmem_addr), 64'd0);
        chk("midrst_data", bmem_wdata, 64'd0);
        rst = 1'b0;
        quiet(8);
        issue(32'hFEDC_BA9F, line_d, 0, 1'b0, 1'b0);   // recovery after reset
        quiet(4);

        chk("queue_drained", 64'(q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/cacheline_burst_writer.md
# cacheline_burst_writer

Write-side memory adapter that takes one 256-bit dirty cache line from the data cache's downstream port and transmits it to burst memory as four consecutive 64-bit beats. It is the transmit counterpart of the line-fill adapter, which assembles four received 64-bit beats into a line. It sits between the data cache write-back path and the shared burst-memory interface; a single `dfp_resp` completes each request.

## Interface
Parameters:
- `LINE_WIDTH`, 256: cache line width in bits
- `BEAT_WIDTH`, 64: burst-memory data width per beat; `BEATS = LINE_WIDTH/BEAT_WIDTH` (4) is derived

Ports:
- `clk`  in  1  single clock; all state updates on rising edge
- `rst`  in  1  synchronous, active-high reset
- `dfp_addr`  in  32  line address from cache; bits [4:0] ignored
- `dfp_write`  in  1  write-back request; held high until `dfp_resp`
- `dfp_wdata`  in  LINE_WIDTH  line data, beat 0 = bits [63:0]
- `dfp_resp`  out  1  one-cycle completion pulse
- `busy`  out  1  high in any state other than IDLE
- `bmem_addr`  out  32  burst address, line-aligned ({addr[31:5], 5'b0})
- `bmem_write`  out  1  write beat valid
- `bmem_wdata`  out  BEAT_WIDTH  current beat data
- `bmem_ready`  in  1  memory can accept a new burst

## Operation
- State machine: IDLE, BURST, RESP. Uses a 2-bit beat counter `beat` (wraps naturally at BEATS=4).
- IDLE: if `dfp_write`=1, latch aligned address and full line into internal registers, clear `beat` to 0, go to BURST. Otherwise stay.
- BURST: drive `bmem_write`=1, `bmem_addr`=latched address, `bmem_wdata`=line[beat*64 +: 64].
  - When `beat`==0, advance only if `bmem_ready`=1. Otherwise hold beat 0 with `bmem_write` still high.
  - When `beat` is 1–3, advance unconditionally. Once the first beat is accepted, memory accepts the rest back-to-back.
  - When `beat`==3 is issued, go to RESP.
- RESP: `dfp_resp`=1 for exactly one cycle, then go to IDLE. `dfp_write` is ignored in RESP.
- Line and address registers are frozen from capture until return to IDLE. Changes on `dfp_addr`/`dfp_wdata` during BURST have no effect.
- `bmem_addr`/`bmem_wdata` are 0 whenever `bmem_write`=0.

## Timing
- Reset (cycle after `rst` sampled high): state IDLE, `beat`=0, `dfp_resp`=0, `busy`=0, `bmem_write`=0, `bmem_addr`=0, `bmem_wdata`=0, line register cleared.
- Outputs are decoded from registered state only. There are no combinational input-to-output paths.
- Request sampled in IDLE at cycle N gives beat 0 at N+1. With `bmem_ready`=1, beats occupy N+1..N+4, `dfp_resp` is at N+5, and IDLE is at N+6. Minimum turnaround is 6 cycles per line.
- Each cycle `bmem_ready`=0 at beat 0 adds one cycle. `bmem_ready` is ignored for beats 1–3.
- The requester drops `dfp_write` in the cycle after `dfp_resp`, which is the IDLE cycle. If `dfp_write` is still high in that IDLE cycle, it is a new request and is captured.
- Reset mid-burst abandons the burst. `bmem_write` is 0 in the next cycle, and no `dfp_resp` is generated.
- Reset and `dfp_write` asserted together: reset wins, and nothing is captured.

## Test plan
- Basic write: `bmem_ready`=1; `dfp_addr`=0x1234_567F; `dfp_wdata`={64'hDDDD…, 64'hCCCC…, 64'hBBBB…, 64'hAAAA…}.
  - Required: `bmem_addr`=0x1234_5660 for 4 consecutive cycles.
  - Required: `bmem_wdata` sequence AAAA, BBBB, CCCC, DDDD.
  - Required: `dfp_resp` for 1 cycle at request+5.
- Backpressure: `bmem_ready`=0 for 3 cycles after capture, then 1.
  - Required: beat 0 held with `bmem_write`=1 for 4 cycles total, then beats 1–3 back-to-back.
  - Required: `dfp_resp` at request+8.
- Ready drop mid-burst: `bmem_ready` goes 0 during beats 1–3.
  - Required: beats continue uninterrupted, with unchanged timing from the basic case.
- Input change during burst: change `dfp_wdata` to all-ones and `dfp_addr` to 0xFFFF_FFE0 during BURST.
  - Required: emitted beats and address match the originally captured values.
- Back-to-back requests: keep `dfp_write` high across the IDLE cycle after `dfp_resp` with a new line.
  - Required: second burst starts at the following cycle with the new data.
  - Required: `busy` low for exactly that one IDLE cycle.
- Reset mid-operation: assert `rst` during beat 2.
  - Required: next cycle all outputs are 0 and state is IDLE.
  - Required: no `dfp_resp` is produced.
  - Required: a subsequent request completes normally.
